// File: rtl/window_stream_ctrl.sv
// Sequences one raster frame through the sliding-window line buffer: pixel intake, zero flush,
// and one output beat per centre pixel. Optional tap_mask port under WINDOW_TAP_MASK_EN.
module window_stream_ctrl #(
  parameter int unsigned NUMBER_OF_LINES = 3,
  parameter int unsigned WIDTH           = 640,
  parameter int unsigned HEIGHT          = 480
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       in_valid,
  input  logic                                       in_sof,
  output logic                                       in_ready,
  output logic                                       win_en,
  output logic                                       pad_sel,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [$clog2(WIDTH)-1:0]                   out_x,
  output logic [$clog2(HEIGHT)-1:0]                  out_y,
  output logic                                       out_border,
`ifdef WINDOW_TAP_MASK_EN
  output logic [NUMBER_OF_LINES*NUMBER_OF_LINES-1:0] tap_mask,
`endif
  output logic                                       busy,
  output logic                                       frame_done,
  output logic                                       sof_err
);

  localparam int unsigned N      = NUMBER_OF_LINES;
  localparam int unsigned H      = (N - 1) / 2;
  localparam int unsigned XW     = $clog2(WIDTH);
  localparam int unsigned YW     = $clog2(HEIGHT);
  localparam int unsigned Frame  = WIDTH * HEIGHT;
  localparam int unsigned Offset = (N - H) * WIDTH - H;
  localparam int unsigned FlushN = Offset - 1;
  localparam int unsigned SW     = $clog2(Frame + Offset + 1);

  localparam logic [SW-1:0] SFrame   = SW'(Frame);
  localparam logic [SW-1:0] SOffset  = SW'(Offset);
  localparam logic [SW-1:0] SEnd     = SW'(Frame + FlushN);
  localparam logic [SW-1:0] SBeatEnd = SW'(Frame + Offset);
  localparam logic [XW-1:0] XLast    = XW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d, s_inc;
  logic            valid_q, valid_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            border_q, border_d;
  logic            frame_done_q, frame_done_d;
  logic            sof_err_q, sof_err_d;
  logic            adv, beat_hit;
`ifdef WINDOW_TAP_MASK_EN
  logic [N*N-1:0]  mask_q, mask_d;
`endif

  // Control FSM: handshake, shift enable and frame sequencing
  always_comb begin
    adv          = !valid_q || out_ready;
    state_d      = state_q;
    in_ready     = 1'b0;
    win_en       = 1'b0;
    pad_sel      = 1'b0;
    sof_err_d    = 1'b0;
    frame_done_d = 1'b0;
    s_inc        = (state_q == StIdle) ? SW'(1) : s_q + SW'(1);
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          win_en  = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        in_ready  = adv;
        win_en    = in_valid && adv;
        sof_err_d = in_valid && adv && in_sof;
        if (win_en && s_inc == SFrame) state_d = (FlushN == 0) ? StDrain : StFlush;
      end
      StFlush: begin
        pad_sel = 1'b1;
        win_en  = adv;
        if (win_en && s_inc == SEnd) state_d = StDrain;
      end
      StDrain: begin
        if (adv) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    s_d = win_en ? s_inc : s_q;
  end

  // Beat generation: shift s yields centre c = s - Offset one cycle later
  always_comb begin
    int unsigned xi, yi;
    int          tx, ty;
    valid_d  = valid_q;
    x_d      = x_q;
    y_d      = y_q;
    border_d = border_q;
    xi       = 0;
    yi       = 0;
    tx       = 0;
    ty       = 0;
`ifdef WINDOW_TAP_MASK_EN
    mask_d   = mask_q;
`endif
    beat_hit = win_en && (s_inc >= SOffset) && (s_inc < SBeatEnd);
    if (beat_hit) begin
      valid_d = 1'b1;
      if (s_inc == SOffset) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == XLast) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      xi       = 32'(x_d);
      yi       = 32'(y_d);
      border_d = (xi < H) || (xi >= WIDTH - H) || (yi < H) || (yi >= HEIGHT - H);
`ifdef WINDOW_TAP_MASK_EN
      for (int j = 0; j < int'(N); j++) begin
        for (int i = 0; i < int'(N); i++) begin
          ty = int'(yi) + j - int'(H);
          tx = int'(xi) + i - int'(H);
          mask_d[j*int'(N)+i] = (tx >= 0) && (tx < int'(WIDTH)) &&
                                (ty >= 0) && (ty < int'(HEIGHT));
        end
      end
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      s_q          <= '0;
      valid_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      border_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
`ifdef WINDOW_TAP_MASK_EN
      mask_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      valid_q      <= valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      border_q     <= border_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
`ifdef WINDOW_TAP_MASK_EN
      mask_q       <= mask_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_border = border_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
`ifdef WINDOW_TAP_MASK_EN
  assign tap_mask   = mask_q;
`endif

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Randomised bench for window_stream_ctrl (N=3, 4x3 frame) against a frame-level reference model.
module tb_window_stream_ctrl;

  localparam int N       = 3;
  localparam int W       = 4;
  localparam int HT      = 3;
  localparam int H       = (N - 1) / 2;
  localparam int FRAME   = W * HT;
  localparam int OFFSET  = (N - H) * W - H;
  localparam int FLUSH_N = OFFSET - 1;

  logic       clock = 1'b0;
  logic       reset_n, in_valid, in_sof, in_ready, win_en, pad_sel;
  logic       out_valid, out_ready, out_border, busy, frame_done, sof_err;
  logic [1:0] out_x;
  logic [1:0] out_y;
`ifdef WINDOW_TAP_MASK_EN
  logic [8:0] tap_mask;
`endif

  window_stream_ctrl #(
    .NUMBER_OF_LINES(N),
    .WIDTH          (W),
    .HEIGHT         (HT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .win_en    (win_en),
    .pad_sel   (pad_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_border(out_border),
`ifdef WINDOW_TAP_MASK_EN
    .tap_mask  (tap_mask),
`endif
    .busy      (busy),
    .frame_done(frame_done),
    .sof_err   (sof_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase, shift count and the beat currently presented
  typedef enum int {MIdle, MStream, MFlush, MDrain} mphase_e;
  mphase_e ph;
  int      n, m_x, m_y;
  bit      m_ov, m_fd, m_se;

  task automatic model_reset();
    ph   = MIdle;
    n    = 0;
    m_ov = 1'b0;
    m_x  = 0;
    m_y  = 0;
    m_fd = 1'b0;
    m_se = 1'b0;
  endtask

  function automatic bit border_of(input int x, input int y);
    return (x < H) || (x >= W - H) || (y < H) || (y >= HT - H);
  endfunction

  function automatic logic [8:0] mask_of(input int x, input int y);
    logic [8:0] m;
    m = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        m[j*N+i] = (x + i - H >= 0) && (x + i - H < W) && (y + j - H >= 0) && (y + j - H < HT);
    return m;
  endfunction

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_frame(input int garbage, input int rdy_mode, input bit vrand,
                           input bit sof_again, input bit abort);
    int garb, sent, beats, dones, sofs, shifts, c;
    bit first, e_ir, e_we, adv;
    garb = garbage; sent = 0; beats = 0; dones = 0; sofs = 0; shifts = 0; first = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_x", out_x, m_x);
        check("out_y", out_y, m_y);
        check("out_border", out_border, border_of(m_x, m_y));
`ifdef WINDOW_TAP_MASK_EN
        check("tap_mask", tap_mask, mask_of(m_x, m_y));
`endif
      end
      check("frame_done", frame_done, m_fd);
      check("sof_err", sof_err, m_se);
      check("busy", busy, ph != MIdle);
      if (out_valid && first) begin
        check("first_beat_shift", shifts, OFFSET);
        first = 1'b0;
      end
      if (frame_done) dones++;
      if (sof_err) sofs++;
      if (dones > 0 && ph == MIdle) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        m_fd     = 1'b0;
        m_se     = 1'b0;
        break;
      end

      in_valid = (ph == MIdle || ph == MStream) && sent < FRAME &&
                 (!vrand || $urandom_range(3) != 0);
      in_sof   = in_valid && garb == 0 && (sent == 0 || (sof_again && sent == 5));
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      #1;
      adv = !m_ov || out_ready;
      case (ph)
        MIdle:   begin e_ir = 1'b1; e_we = in_valid && in_sof; end
        MStream: begin e_ir = adv;  e_we = in_valid && adv;    end
        MFlush:  begin e_ir = 1'b0; e_we = adv;                end
        default: begin e_ir = 1'b0; e_we = 1'b0;               end
      endcase
      check("in_ready", in_ready, e_ir);
      check("win_en", win_en, e_we);
      if (e_we) check("pad_sel", pad_sel, ph == MFlush);
      if (out_valid && !out_ready) check("hold_no_shift", win_en, 1'b0);
      if (win_en) shifts++;
      if (out_valid && out_ready) begin
        check("seq_x", out_x, beats % W);
        check("seq_y", out_y, beats / W);
        beats++;
      end
      if (in_valid && e_ir) begin
        if (garb > 0) garb--;
        else sent++;
      end

      m_se = (ph == MStream) && in_valid && adv && in_sof;
      m_fd = 1'b0;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (e_we) begin
        n = (ph == MIdle) ? 1 : n + 1;
        c = n - OFFSET;
        if (c >= 0 && c < FRAME) begin
          m_ov = 1'b1;
          m_x  = c % W;
          m_y  = c / W;
        end
      end
      case (ph)
        MIdle:   if (e_we) ph = MStream;
        MStream: if (e_we && n == FRAME) ph = (FLUSH_N == 0) ? MDrain : MFlush;
        MFlush:  if (e_we && n == FRAME + FLUSH_N) ph = MDrain;
        default: if (adv) begin m_fd = 1'b1; ph = MIdle; end
      endcase

      if (abort && ph == MFlush && n == FRAME + 3) begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_frame_done", frame_done, 1'b0);
        model_reset();
        @(negedge clock);
        check("abort_hold_done", frame_done, 1'b0);
        reset_n = 1'b1;
        return;
      end
    end
    check("beats_per_frame", beats, FRAME);
    check("frame_done_count", dones, 1);
    check("sof_err_count", sofs, sof_again);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_border", out_border, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_sof_err", sof_err, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    run_frame(0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1, 1'b0, 1'b0, 1'b0);
    run_frame(3, 0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 0, 1'b0, 1'b1, 1'b0);
    run_frame(0, 0, 1'b0, 1'b0, 1'b1);
    run_frame(0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) run_frame(int'($urandom_range(2)), 2, 1'b1, k[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/window_stream_ctrl.md
Name: window_stream_ctrl

Overview:
- Sequences one raster frame through the line-buffer sliding window of the convolutional blur datapath.
- Accepts a pixel stream with a valid/ready handshake and drives the window shift enable.
- After the last real pixel, injects zero-padded flush shifts so that every pixel becomes a window centre exactly once.
- Emits one output beat per centre pixel, carrying its coordinates and border status, with backpressure from the blur arithmetic stage.

Parameters:
- NUMBER_OF_LINES, 3, window edge N; odd, ≥3; H = (N-1)/2.
- WIDTH, 640, frame width in pixels; ≥N.
- HEIGHT, 480, frame height in lines; ≥N.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream pixel valid.
- in_sof  in  1  marks first pixel of a frame; qualified by in_valid.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- win_en  out  1  shift enable to sliding window, combinational.
- pad_sel  out  1  1 = window data mux selects zero (flush), combinational.
- out_valid  out  1  window centred on (out_x,out_y) is stable and valid.
- out_ready  in  1  downstream consumes beat when out_valid & out_ready.
- out_x  out  $clog2(WIDTH)  centre column.
- out_y  out  $clog2(HEIGHT)  centre line.
- out_border  out  1  window extends past any frame edge (taps wrap or are padded).
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse after the final beat is consumed.
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Definitions:
  - FRAME = WIDTH*HEIGHT.
  - OFFSET = (N-H)*WIDTH - H.
  - FLUSH_N = OFFSET-1.
  - s = shift counter, counting shifts since frame start.
- Reset (async, reset_n low):
  - state = IDLE; s, out_x, out_y = 0.
  - out_valid, out_border, frame_done, sof_err = 0.
  - Shift register contents are not cleared.
- adv = !out_valid | out_ready. No shift may occur while a beat is held, so the window stays stable for the whole beat.
- IDLE:
  - in_ready = 1, win_en = 0.
  - Pixels without in_sof are accepted and discarded.
  - An accepted pixel with in_sof sets win_en = 1 that cycle, sets s = 1, and moves to STREAM.
- STREAM:
  - in_ready = adv, win_en = in_valid & adv, pad_sel = 0.
  - Each shift increments s.
  - After shift s = FRAME, go to FLUSH; go to DRAIN instead if FLUSH_N = 0.
  - in_sof on an accepted pixel pulses sof_err, and the pixel is treated as ordinary data.
- FLUSH:
  - in_ready = 0, pad_sel = 1, win_en = adv, s increments.
  - After shift s = FRAME + FLUSH_N, go to DRAIN.
- DRAIN:
  - in_ready = 0, win_en = 0.
  - Once out_valid is 0, or is consumed this cycle, pulse frame_done next cycle and return to IDLE.
- Output generation, for every shift number s:
  - c = s - OFFSET.
  - If 0 ≤ c < FRAME, the next cycle has out_valid = 1, out_x = c mod WIDTH, out_y = c / WIDTH.
  - Otherwise out_valid is cleared when consumed.
  - Latency: 1 cycle from shift to beat.
  - Coordinates come from incrementing x/y counters; no divider.
- out_border = (x < H) | (x ≥ WIDTH-H) | (y < H) | (y ≥ HEIGHT-H), registered with the beat.
- Exactly FRAME beats per frame, in raster order; no beat is duplicated or skipped under any out_ready pattern.
- Simultaneous consume and shift in one cycle are allowed; a new beat replaces the consumed one without a bubble.
- Reset mid-frame aborts immediately: no frame_done, state IDLE.

Optional Feature:
- Macro: WINDOW_TAP_MASK_EN.
- Defined:
  - Extra output tap_mask [N*N-1:0], registered with each beat.
  - Bit (j*N + i) = 1 iff tap at line offset j-H and column offset i-H from the centre lies inside the frame.
  - Downstream uses the mask to renormalise the blur at edges.
- Undefined: port absent; only out_border is provided.

Test Plan:
- N=3, W=4, H=3, continuous in_valid with in_sof on pixel 0, out_ready=1 -> 12 pixels shifted, then 6 flush shifts with pad_sel=1.
  - First out_valid the cycle after shift 7, with (0,0) and border=1.
  - 12 beats in raster order, e.g. beat 5 = (1,1) border=0.
  - frame_done exactly once.
- Same setup, out_ready toggling 1,0,0,1 -> win_en never high while out_valid&!out_ready; same 12 beats and coordinates; no loss or duplication.
- Idle garbage: 3 pixels without in_sof, then frame -> garbage accepted with win_en=0; first beat still after the 7th frame shift.
- in_sof reasserted on pixel 5 -> one sof_err pulse; output sequence unchanged.
- reset_n low during FLUSH -> out_valid=0, busy=0 asynchronously; no frame_done; next frame behaves as in the first test.
- With WINDOW_TAP_MASK_EN, N=3, W=4, H=3 -> beat (0,0) tap_mask=9'b110110000; beat (1,1) tap_mask=9'h1FF.
